// File: rtl/sum_bus_accumulator_if.sv
// Bus between the tri-state adder result and the accumulator, plus the
// accumulator's result handshake to the next stage.
interface sum_bus_accumulator_if #(
    parameter int DATA_W = 4,
    parameter int ACC_W  = 8
);
    logic              bus_en;
    logic [DATA_W-1:0] bus_data;
    logic [ACC_W-1:0]  acc_data;
    logic              acc_valid;
    logic              acc_ready;

    modport master (
        output bus_en, bus_data, acc_ready,
        input  acc_data, acc_valid
    );

    modport slave (
        input  bus_en, bus_data, acc_ready,
        output acc_data, acc_valid
    );
endinterface

// File: rtl/sum_bus_accumulator.sv
// Accumulates BURST_LEN driven samples of the adder result bus and offers the
// sum downstream; floating bus cycles (bus_en=0) are never looked at.
module sum_bus_accumulator #(
    parameter int  DATA_W    = 4,
    parameter int  ACC_W     = 8,
    parameter int  BURST_LEN = 4,
    localparam int CNT_W     = $clog2(BURST_LEN + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr,
    sum_bus_accumulator_if.slave bus,
    output logic [CNT_W-1:0]     sample_cnt,
    output logic                 overflow,
    output logic                 drop,
    output logic [0:0]           fsm_state
);
    localparam logic [0:0] ACCUM = 1'b0;
    localparam logic [0:0] HOLD  = 1'b1;

    logic [0:0]       state_q;
    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] sample_z;
    logic [ACC_W:0]   sum;
    logic             last_sample;
    logic             handshake;

    // Gate the bus before use so a floating Z/X bus never reaches the sum.
    assign sample_z    = bus.bus_en ? ACC_W'(bus.bus_data) : '0;
    assign sum         = {1'b0, acc_q} + {1'b0, sample_z};
    assign last_sample = (sample_cnt == CNT_W'(BURST_LEN - 1));

    // Result handshake: acc_data is offered while acc_valid=1 and is consumed
    // on a rising edge with acc_valid & acc_ready; valid only falls after that
    // transfer (or on clr/reset), and acc_data is stable while valid is high.
    assign handshake = (state_q == HOLD) && bus.acc_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ACCUM;
            acc_q      <= '0;
            sample_cnt <= '0;
            overflow   <= 1'b0;
            drop       <= 1'b0;
        end else if (clr) begin
            state_q    <= ACCUM;
            acc_q      <= '0;
            sample_cnt <= '0;
            overflow   <= 1'b0;
            drop       <= 1'b0;
        end else begin
            case (state_q)
                ACCUM: begin
                    if (bus.bus_en) begin
                        acc_q      <= sum[ACC_W-1:0];
                        overflow   <= overflow | sum[ACC_W];
                        sample_cnt <= sample_cnt + 1'b1;
                        if (last_sample) state_q <= HOLD;
                    end
                end
                HOLD: begin
                    if (handshake) begin
                        // A sample arriving with the handshake opens the next burst.
                        state_q    <= ACCUM;
                        acc_q      <= sample_z;
                        sample_cnt <= bus.bus_en ? CNT_W'(1) : '0;
                    end else if (bus.bus_en) begin
                        drop <= 1'b1;
                    end
                end
                default: state_q <= ACCUM;
            endcase
        end
    end

    assign bus.acc_data  = acc_q;
    assign bus.acc_valid = (state_q == HOLD);
    assign fsm_state     = state_q;
endmodule

// File: tb/tb_sum_bus_accumulator.sv
// Directed bench for sum_bus_accumulator: an 8-bit accumulator for the main
// scenarios and a 5-bit one for overflow behaviour.
module tb_sum_bus_accumulator;
  logic clk;
  logic rst_n;
  logic clr_a;
  logic clr_b;
  logic [2:0] cnt_a, cnt_b;
  logic ovf_a, ovf_b, drop_a, drop_b;
  logic [0:0] st_a, st_b;

  int n_checks = 0;
  int n_fail = 0;
  logic [7:0] exp_q[$];

  sum_bus_accumulator_if #(.DATA_W(4), .ACC_W(8)) bus_a ();
  sum_bus_accumulator_if #(.DATA_W(4), .ACC_W(5)) bus_b ();

  sum_bus_accumulator #(.DATA_W(4), .ACC_W(8), .BURST_LEN(4)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .clr(clr_a), .bus(bus_a.slave),
    .sample_cnt(cnt_a), .overflow(ovf_a), .drop(drop_a), .fsm_state(st_a)
  );

  sum_bus_accumulator #(.DATA_W(4), .ACC_W(5), .BURST_LEN(4)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .clr(clr_b), .bus(bus_b.slave),
    .sample_cnt(cnt_b), .overflow(ovf_b), .drop(drop_b), .fsm_state(st_b)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // driver tasks for accumulator A
  task automatic drive_a(input logic en, input logic [3:0] data, input logic rdy);
    bus_a.bus_en    = en;
    bus_a.bus_data  = en ? data : 4'bz;
    bus_a.acc_ready = rdy;
    step();
  endtask

  task automatic drive_b(input logic en, input logic [3:0] data, input logic rdy);
    bus_b.bus_en    = en;
    bus_b.bus_data  = en ? data : 4'bz;
    bus_b.acc_ready = rdy;
    step();
  endtask

  // scoreboard: compare the held result against the oldest expected burst sum
  task automatic check_result(input string tag);
    logic [7:0] exp;
    if (exp_q.size() == 0) begin
      check_eq({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      exp = exp_q.pop_front();
      check_eq({tag, "_valid"}, {31'd0, bus_a.acc_valid}, 32'd1);
      check_eq({tag, "_data"}, {24'd0, bus_a.acc_data}, {24'd0, exp});
      check_eq({tag, "_cnt"}, {29'd0, cnt_a}, 32'd4);
    end
  endtask

  initial begin
    logic [3:0] vec1 [4];
    logic [3:0] vec2 [4];
    vec1 = '{4'hA, 4'hC, 4'hE, 4'h0};
    vec2 = '{4'h1, 4'h2, 4'h3, 4'h4};

    rst_n = 1'b0;
    clr_a = 1'b0;
    clr_b = 1'b0;
    bus_a.bus_en = 1'b0; bus_a.bus_data = 4'bz; bus_a.acc_ready = 1'b0;
    bus_b.bus_en = 1'b0; bus_b.bus_data = 4'bz; bus_b.acc_ready = 1'b0;
    #3;
    check_eq("rst_data", {24'd0, bus_a.acc_data}, 32'd0);
    check_eq("rst_valid", {31'd0, bus_a.acc_valid}, 32'd0);
    check_eq("rst_cnt", {29'd0, cnt_a}, 32'd0);
    check_eq("rst_flags", {30'd0, ovf_a, drop_a}, 32'd0);
    #9 rst_n = 1'b1;
    step();

    // 1: consecutive samples A,C,E,0 with ready held high
    for (int i = 0; i < 4; i++) begin
      drive_a(1'b1, vec1[i], 1'b1);
      check_eq($sformatf("t1_cnt%0d", i), {29'd0, cnt_a}, i + 1);
      if (i < 3) check_eq($sformatf("t1_novalid%0d", i), {31'd0, bus_a.acc_valid}, 32'd0);
    end
    exp_q.push_back(8'h24);
    check_result("t1");
    check_eq("t1_ovf", {31'd0, ovf_a}, 32'd0);
    drive_a(1'b0, 4'h0, 1'b1);
    check_eq("t1_release", {31'd0, bus_a.acc_valid}, 32'd0);
    check_eq("t1_cnt_clr", {29'd0, cnt_a}, 32'd0);

    // 2: bus_en alternates, Z on idle cycles
    for (int i = 0; i < 4; i++) begin
      drive_a(1'b1, vec2[i], 1'b1);
      check_eq($sformatf("t2_cnt_drv%0d", i), {29'd0, cnt_a}, i + 1);
      if (i < 3) begin
        drive_a(1'b0, 4'h0, 1'b1);
        check_eq($sformatf("t2_cnt_idle%0d", i), {29'd0, cnt_a}, i + 1);
      end
    end
    exp_q.push_back(8'h0A);
    check_result("t2");
    drive_a(1'b0, 4'h0, 1'b1);

    // 3: result held against back-pressure while the bus keeps driving
    for (int i = 0; i < 4; i++) drive_a(1'b1, vec1[i], 1'b0);
    for (int i = 0; i < 5; i++) drive_a(1'b1, 4'h5, 1'b0);
    exp_q.push_back(8'h24);
    check_result("t3");
    check_eq("t3_drop", {31'd0, drop_a}, 32'd1);
    drive_a(1'b0, 4'h0, 1'b1);
    check_eq("t3_valid_off", {31'd0, bus_a.acc_valid}, 32'd0);
    check_eq("t3_cnt_zero", {29'd0, cnt_a}, 32'd0);
    check_eq("t3_drop_sticky", {31'd0, drop_a}, 32'd1);

    // 4: sample in the handshake cycle starts the next burst
    for (int i = 0; i < 4; i++) drive_a(1'b1, 4'h1, 1'b0);
    exp_q.push_back(8'h04);
    check_result("t4_first");
    drive_a(1'b1, 4'h7, 1'b1);
    check_eq("t4_hs_valid", {31'd0, bus_a.acc_valid}, 32'd0);
    check_eq("t4_hs_data", {24'd0, bus_a.acc_data}, 32'h07);
    check_eq("t4_hs_cnt", {29'd0, cnt_a}, 32'd1);
    for (int i = 0; i < 3; i++) drive_a(1'b1, 4'h1, 1'b0);
    exp_q.push_back(8'h0A);
    check_result("t4_second");

    // clr with a sample in the same cycle: sample discarded, no drop
    clr_a = 1'b1;
    drive_a(1'b1, 4'h3, 1'b0);
    clr_a = 1'b0;
    check_eq("clr_data", {24'd0, bus_a.acc_data}, 32'd0);
    check_eq("clr_valid", {31'd0, bus_a.acc_valid}, 32'd0);
    check_eq("clr_cnt", {29'd0, cnt_a}, 32'd0);
    check_eq("clr_drop", {31'd0, drop_a}, 32'd0);
    drive_a(1'b0, 4'h0, 1'b0);

    // 5: 5-bit accumulator overflow
    drive_b(1'b1, 4'hF, 1'b0);
    check_eq("t5_s1", {27'd0, bus_b.acc_data}, 32'd15);
    drive_b(1'b1, 4'hF, 1'b0);
    check_eq("t5_s2_ovf", {31'd0, ovf_b}, 32'd0);
    drive_b(1'b1, 4'hF, 1'b0);
    check_eq("t5_s3_ovf", {31'd0, ovf_b}, 32'd1);
    check_eq("t5_s3_data", {27'd0, bus_b.acc_data}, 32'd13);
    drive_b(1'b1, 4'hF, 1'b0);
    check_eq("t5_data", {27'd0, bus_b.acc_data}, 32'h1C);
    check_eq("t5_valid", {31'd0, bus_b.acc_valid}, 32'd1);
    drive_b(1'b0, 4'h0, 1'b1);
    for (int i = 0; i < 4; i++) drive_b(1'b1, 4'h1, 1'b0);
    check_eq("t5_next_data", {27'd0, bus_b.acc_data}, 32'd4);
    check_eq("t5_ovf_persist", {31'd0, ovf_b}, 32'd1);
    clr_b = 1'b1;
    drive_b(1'b0, 4'h0, 1'b0);
    clr_b = 1'b0;
    check_eq("t5_clr_all", {27'd0, bus_b.acc_data, bus_b.acc_valid, ovf_b, drop_b, st_b}, 32'd0);
    check_eq("t5_clr_cnt", {29'd0, cnt_b}, 32'd0);

    // 6: async reset between edges, mid-burst
    drive_a(1'b1, 4'h6, 1'b0);
    drive_a(1'b1, 4'h6, 1'b0);
    bus_a.bus_en = 1'b0;
    bus_a.bus_data = 4'bz;
    #3 rst_n = 1'b0;
    #1;
    check_eq("t6_rst_data", {24'd0, bus_a.acc_data}, 32'd0);
    check_eq("t6_rst_cnt", {29'd0, cnt_a}, 32'd0);
    check_eq("t6_rst_flags", {29'd0, bus_a.acc_valid, ovf_a, drop_a}, 32'd0);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) drive_a(1'b1, vec2[i] + 4'h1, 1'b0);
    bus_a.bus_en = 1'b0;
    bus_a.bus_data = 4'bz;
    for (int i = 0; i < 3 && !bus_a.acc_valid; i++) step();
    check_eq("t6_valid_timeout", {31'd0, bus_a.acc_valid}, 32'd1);
    exp_q.push_back(8'h0E);
    check_result("t6");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
